// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store initiator for a word-addressed data memory
// Sub-word stores become a read-modify-write that holds the pipeline for one cycle.
module mem_access_ctrl #(
    parameter int ADDR_W     = 5,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              misalign_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_RMW_WR = 1'b1;

    logic [0:0]        state;
    logic [31:0]       merge;
    logic [ADDR_W-1:0] hold_addr;

    logic        is_load;
    logic        is_store;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        sub_store;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [31:0] merge_next;
    logic        unused_addr_bits;

    assign unused_addr_bits = &{1'b0, req_addr[31:ADDR_W+2]};

    // A simultaneous read+write request is decoded as a load.
    always_comb begin
        is_load    = req_valid & req_read;
        is_store   = req_valid & req_write & ~req_read;
        is_half    = (req_size == 2'b01);
        is_word    = req_size[1];
        misaligned = (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));
        sub_store  = is_store & ~is_word & ~misaligned;
    end

    // Lane position in bits; big-endian puts byte offset 0 in bits 31:24.
    always_comb begin
        byte_sh = {(BIG_ENDIAN ? ~req_addr[1:0] : req_addr[1:0]), 3'b000};
        half_sh = {(BIG_ENDIAN ? ~req_addr[1]   : req_addr[1]),   4'b0000};
        rd_byte = mem_rdata[byte_sh +: 8];
        rd_half = mem_rdata[half_sh +: 16];
    end

    always_comb begin
        case (req_size)
            2'b00:   load_data = req_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_data = req_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_data = mem_rdata;
        endcase
        if (is_half)
            merge_next = (mem_rdata & ~(32'h0000_FFFF << half_sh)) | ({16'h0, req_wdata[15:0]} << half_sh);
        else
            merge_next = (mem_rdata & ~(32'h0000_00FF << byte_sh)) | ({24'h0, req_wdata[7:0]} << byte_sh);
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        stall     = 1'b0;
        mem_addr  = req_addr[ADDR_W+1:2];
        mem_wdata = req_wdata;
        if (state == S_RMW_WR) begin
            mem_addr  = hold_addr;
            mem_wdata = merge;
        end
        if (!rst) begin
            if (state == S_RMW_WR) begin
                mem_write = 1'b1;
            end else if (!misaligned) begin
                if (is_load) begin
                    mem_read = 1'b1;
                end else if (is_store) begin
                    if (is_word) begin
                        mem_write = 1'b1;
                    end else begin
                        mem_read = 1'b1;
                        stall    = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            misalign_err <= 1'b0;
            merge        <= 32'h0;
            hold_addr    <= '0;
        end else begin
            resp_valid   <= 1'b0;
            misalign_err <= 1'b0;
            if (state == S_RMW_WR) begin
                state      <= S_IDLE;
                resp_valid <= 1'b1;
                resp_rdata <= 32'h0;
            end else if (is_load || is_store) begin
                if (misaligned) begin
                    resp_valid   <= 1'b1;
                    misalign_err <= 1'b1;
                    resp_rdata   <= 32'h0;
                end else if (is_load) begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_data;
                end else if (sub_store) begin
                    merge     <= merge_next;
                    hold_addr <= req_addr[ADDR_W+1:2];
                    state     <= S_RMW_WR;
                end else begin
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a behavioural data memory
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign_err;
    logic [4:0]  mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:31];
    logic [32:0] exp_q [$];
    int tests = 0;
    int fails = 0;

    mem_access_ctrl #(.ADDR_W(5), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign_err(misalign_err),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write && !mem_read) mem[mem_addr] = mem_wdata;
    end

    // Response monitor: pops {misalign_err, resp_rdata} expectations in order.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst) begin
            tests++;
            if (mem_read && mem_write) begin
                fails++;
                $display("FAIL both_enables: mem_read=%0b mem_write=%0b required not both 1", mem_read, mem_write);
            end
            if (resp_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_resp: resp_rdata=%h err=%0b with nothing expected", resp_rdata, misalign_err);
                end else begin
                    e = exp_q.pop_front();
                    if ({misalign_err, resp_rdata} !== e) begin
                        fails++;
                        $display("FAIL resp: got err=%0b data=%h, required err=%0b data=%h",
                                 misalign_err, resp_rdata, e[32], e[31:0]);
                    end
                end
            end else if (misalign_err !== 1'b0) begin
                tests++;
                fails++;
                $display("FAIL err_without_valid: misalign_err=%0b required 0", misalign_err);
            end
        end
    end

    task automatic issue_load(input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] exp_data);
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
        req_size = size; req_unsigned = uns; req_addr = addr;
        #3;
        tests++;
        if ({mem_read, mem_write, stall, mem_addr} !== {3'b100, addr[6:2]}) begin
            fails++;
            $display("FAIL load_enables @%h: rd/wr/stall/addr=%b/%b/%b/%0d required 1/0/0/%0d",
                     addr, mem_read, mem_write, stall, mem_addr, addr[6:2]);
        end
        exp_q.push_back({1'b0, exp_data});
        @(posedge clk); #1;
        req_valid = 1'b0; req_read = 1'b0;
    endtask

    task automatic issue_store_word(input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
        req_size = 2'b10; req_unsigned = 1'b0; req_addr = addr; req_wdata = data;
        #3;
        tests++;
        if ({mem_read, mem_write, stall, mem_addr, mem_wdata} !== {3'b010, addr[6:2], data}) begin
            fails++;
            $display("FAIL sw_enables @%h: rd/wr/stall=%b%b%b addr=%0d wdata=%h required 010 %0d %h",
                     addr, mem_read, mem_write, stall, mem_addr, mem_wdata, addr[6:2], data);
        end
        exp_q.push_back(33'h0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    task automatic issue_store_sub(input logic [31:0] addr, input logic [1:0] size,
                                   input logic [31:0] data, input logic [31:0] exp_merge);
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
        req_size = size; req_unsigned = 1'b0; req_addr = addr; req_wdata = data;
        #3;
        tests++;
        if ({mem_read, mem_write, stall, mem_addr} !== {3'b101, addr[6:2]}) begin
            fails++;
            $display("FAIL rmw_read @%h: rd/wr/stall=%b%b%b addr=%0d required 101 %0d",
                     addr, mem_read, mem_write, stall, mem_addr, addr[6:2]);
        end
        @(posedge clk); #1;
        #3;
        tests++;
        if ({mem_read, mem_write, stall, mem_addr, mem_wdata} !== {3'b010, addr[6:2], exp_merge}) begin
            fails++;
            $display("FAIL rmw_write @%h: rd/wr/stall=%b%b%b addr=%0d wdata=%h required 010 %0d %h",
                     addr, mem_read, mem_write, stall, mem_addr, mem_wdata, addr[6:2], exp_merge);
        end
        exp_q.push_back(33'h0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    task automatic issue_misaligned(input logic [31:0] addr, input logic [1:0] size, input logic wr);
        req_valid = 1'b1; req_read = ~wr; req_write = wr;
        req_size = size; req_unsigned = 1'b0; req_addr = addr; req_wdata = 32'hDEAD_BEEF;
        #3;
        tests++;
        if ({mem_read, mem_write, stall} !== 3'b000) begin
            fails++;
            $display("FAIL misalign_enables @%h: rd/wr/stall=%b%b%b required 000", addr, mem_read, mem_write, stall);
        end
        exp_q.push_back({1'b1, 32'h0});
        @(posedge clk); #1;
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b1; req_read = 1'b1; req_addr = 32'd48; req_size = 2'b10;
        #3;
        tests++;
        if ({mem_read, mem_write, stall, resp_valid, misalign_err, resp_rdata} !== 37'h0) begin
            fails++;
            $display("FAIL reset_state: rd/wr/stall/rv/err=%b%b%b%b%b data=%h required all 0",
                     mem_read, mem_write, stall, resp_valid, misalign_err, resp_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; req_read = 1'b0;
        #3;
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        issue_load(32'd48, 2'b10, 1'b0, 32'h0000_001E);
        issue_load(32'd51, 2'b00, 1'b0, 32'h0000_001E);
        issue_load(32'd48, 2'b00, 1'b0, 32'h0000_0000);
    endtask

    task automatic test_subword_store();
        issue_store_sub(32'd49, 2'b00, 32'h0000_0080, 32'h0080_001E);
        tests++;
        if (mem[12] !== 32'h0080_001E) begin
            fails++;
            $display("FAIL sb_word12: mem=%h required 0080001e", mem[12]);
        end
        issue_load(32'd49, 2'b00, 1'b0, 32'hFFFF_FF80);
        issue_load(32'd49, 2'b00, 1'b1, 32'h0000_0080);
        issue_store_sub(32'd50, 2'b01, 32'h1234_BEEF, 32'h0080_BEEF);
        tests++;
        if (mem[12] !== 32'h0080_BEEF) begin
            fails++;
            $display("FAIL sh_word12: mem=%h required 0080beef", mem[12]);
        end
        issue_load(32'd50, 2'b01, 1'b0, 32'hFFFF_BEEF);
        issue_load(32'd50, 2'b01, 1'b1, 32'h0000_BEEF);
        issue_load(32'd48, 2'b01, 1'b1, 32'h0000_0080);
    endtask

    task automatic test_misalign();
        issue_misaligned(32'd49, 2'b10, 1'b0);
        issue_misaligned(32'd51, 2'b01, 1'b1);
        issue_misaligned(32'd50, 2'b11, 1'b1);
        tests++;
        if (mem[12] !== 32'h0080_BEEF) begin
            fails++;
            $display("FAIL misalign_word12: mem=%h required 0080beef", mem[12]);
        end
    endtask

    task automatic test_rmw_reset();
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
        req_size = 2'b00; req_addr = 32'd4; req_wdata = 32'h0000_0055;
        #3;
        tests++;
        if ({mem_read, stall} !== 2'b11) begin
            fails++;
            $display("FAIL rmwrst_read: rd/stall=%b%b required 11", mem_read, stall);
        end
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        #3;
        tests++;
        if ({mem_read, mem_write, stall} !== 3'b000) begin
            fails++;
            $display("FAIL rmwrst_enables: rd/wr/stall=%b%b%b required 000", mem_read, mem_write, stall);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #3;
        tests++;
        if ({mem_read, mem_write, stall, resp_valid, misalign_err, resp_rdata, mem[1]} !==
            {5'b00000, 32'h0, 32'hA5A5_A5A5}) begin
            fails++;
            $display("FAIL rmwrst_after: rd/wr/stall/rv/err=%b%b%b%b%b data=%h word1=%h required 00000 0 a5a5a5a5",
                     mem_read, mem_write, stall, resp_valid, misalign_err, resp_rdata, mem[1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        issue_store_word(32'd4, 32'h1234_5678);
        issue_load(32'd4, 2'b10, 1'b0, 32'h1234_5678);
        issue_load(32'd7, 2'b00, 1'b0, 32'h0000_0078);
        issue_store_sub(32'd6, 2'b01, 32'h0000_8001, 32'h1234_8001);
        issue_load(32'd4, 2'b10, 1'b0, 32'h1234_8001);
        issue_load(32'd132, 2'b00, 1'b0, 32'h0000_0012);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[12] = 32'h0000_001E;
        mem[1]  = 32'hA5A5_A5A5;
        test_reset();
        test_loads();
        test_subword_store();
        test_misalign();
        test_rmw_reset();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_resp: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
